handshake_const_receiver: RTL

- Receiving end of a constant-producing dataflow channel: accepts DATA_WIDTH tokens over a valid/ready handshake and buffers them in a 2-slot elastic FIFO.
- Re-emits each token with a 1-bit match flag (token == CONST_VALUE).
- Keeps a saturating count of mismatching tokens.
- Sits downstream of constant generators in the handshake dataflow fabric; used both as a checker and as a decoupling buffer.

---
 rtl/handshake_const_receiver.sv | 108 ++++++++++
 1 files changed

// File: rtl/handshake_const_receiver.sv
// Two-slot elastic receiver: buffers handshake tokens, flags each one against
// CONST_VALUE and keeps a saturating count of the tokens that did not match.
module handshake_const_receiver #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = 'h0003EC22,
  parameter int                    CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_match,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  occ_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  match_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  ins_ready_q, ins_ready_d;
  logic [DATA_WIDTH-1:0] outs_q, outs_d;
  logic                  outs_match_q, outs_match_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  accept, emit, in_match;

  assign outs_valid   = (state_q != EMPTY);
  assign ins_ready    = ins_ready_q;
  assign outs         = outs_q;
  assign outs_match   = outs_match_q;
  assign mismatch_cnt = cnt_q;

  assign accept   = ins_valid & ins_ready_q;
  assign emit     = outs_valid & outs_ready;
  assign in_match = (ins == CONST_VALUE);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q ^ accept;
    rd_ptr_d     = rd_ptr_q ^ emit;
    outs_d       = outs_q;
    outs_match_d = outs_match_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !emit)      state_d = FULL;
        else if (emit && !accept) state_d = EMPTY;
      end
      FULL: if (emit) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    // Output registers follow the new head; a token written this cycle is
    // not in the array yet, so take it straight from the input.
    if (state_d != EMPTY) begin
      if (accept && (wr_ptr_q == rd_ptr_d)) begin
        outs_d       = ins;
        outs_match_d = in_match;
      end else begin
        outs_d       = data_q[rd_ptr_d];
        outs_match_d = match_q[rd_ptr_d];
      end
    end

    if (accept && !in_match && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

    ins_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      ins_ready_q  <= 1'b0;
      outs_q       <= '0;
      outs_match_q <= 1'b0;
      cnt_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        match_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ins_ready_q  <= ins_ready_d;
      outs_q       <= outs_d;
      outs_match_q <= outs_match_d;
      cnt_q        <= cnt_d;
      if (accept) begin
        data_q[wr_ptr_q]  <= ins;
        match_q[wr_ptr_q] <= in_match;
      end
    end
  end

endmodule
